// File: rtl/signal_derepeater.sv
// signal_derepeater: majority-combines NREP in-order repetitions of an NBITS frame
// and streams out the voted bits together with their per-position ones counts.
`default_nettype none

module signal_derepeater #(
  parameter int NBITS = 96,
  parameter int NREP  = 10
) (
  input  logic       clk_i,
  input  logic       rst,
  input  logic       clr,
  input  logic       di,
  input  logic       di_vld,
  output logic       busy,
  output logic       do_bit,
  output logic [3:0] do_cnt,
  output logic       do_vld,
  output logic       do_last,
  output logic       err
);

  localparam int         c_PW   = (NBITS > 1) ? $clog2(NBITS + 1) : 1;
  localparam int         c_RW   = (NREP > 1) ? $clog2(NREP) : 1;
  localparam logic [3:0] c_HALF = 4'(NREP / 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t            r_state;
  logic [c_PW-1:0]   r_wr_pos;
  logic [c_PW-1:0]   r_rd_pos;
  logic [c_RW-1:0]   r_rep;
  logic [3:0]        r_cnt [NBITS];
  logic [3:0]        r_sel_cnt;
  logic              r_sel_vld;
  logic              r_sel_last;

  logic w_accept;
  logic w_wrap;
  logic w_last_rep;

  assign w_accept   = di_vld && !clr && (r_state != S_OUT);
  assign w_wrap     = (r_wr_pos == c_PW'(NBITS - 1));
  assign w_last_rep = (r_rep == c_RW'(NREP - 1));

  // The first repetition loads rather than adds, so no clear pass is needed.
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      if (r_rep == '0) begin
        r_cnt[r_wr_pos] <= {3'b000, di};
      end else begin
        r_cnt[r_wr_pos] <= r_cnt[r_wr_pos] + {3'b000, di};
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_wr_pos   <= '0;
      r_rd_pos   <= '0;
      r_rep      <= '0;
      r_sel_cnt  <= '0;
      r_sel_vld  <= 1'b0;
      r_sel_last <= 1'b0;
      busy       <= 1'b0;
      do_bit     <= 1'b0;
      do_cnt     <= '0;
      do_vld     <= 1'b0;
      do_last    <= 1'b0;
      err        <= 1'b0;
    end else if (clr) begin
      r_state    <= S_IDLE;
      r_wr_pos   <= '0;
      r_rd_pos   <= '0;
      r_rep      <= '0;
      r_sel_vld  <= 1'b0;
      r_sel_last <= 1'b0;
      busy       <= 1'b0;
      do_bit     <= 1'b0;
      do_cnt     <= '0;
      do_vld     <= 1'b0;
      do_last    <= 1'b0;
      err        <= 1'b0;
    end else begin
      err        <= di_vld && (r_state == S_OUT);
      // Output stage: one register after the counter read, zero when idle.
      do_vld     <= r_sel_vld;
      do_last    <= r_sel_last;
      do_cnt     <= r_sel_vld ? r_sel_cnt : 4'd0;
      do_bit     <= r_sel_vld && (r_sel_cnt > c_HALF);
      r_sel_vld  <= 1'b0;
      r_sel_last <= 1'b0;

      case (r_state)
        S_IDLE, S_ACC: begin
          if (di_vld) begin
            r_state <= S_ACC;
            if (w_wrap) begin
              r_wr_pos <= '0;
              if (w_last_rep) begin
                r_rep    <= '0;
                r_rd_pos <= '0;
                r_state  <= S_OUT;
              end else begin
                r_rep <= r_rep + c_RW'(1);
              end
            end else begin
              r_wr_pos <= r_wr_pos + c_PW'(1);
            end
          end
        end
        S_OUT: begin
          busy <= 1'b1;
          if (r_rd_pos < c_PW'(NBITS)) begin
            r_sel_vld  <= 1'b1;
            r_sel_cnt  <= r_cnt[r_rd_pos];
            r_sel_last <= (r_rd_pos == c_PW'(NBITS - 1));
            r_rd_pos   <= r_rd_pos + c_PW'(1);
          end
          // Leave OUT on the edge after the final bit has been presented.
          if (do_last) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_signal_derepeater.sv
// tb_signal_derepeater: randomized frames against a counting reference model, scoreboard-checked.
`default_nettype none

module tb_signal_derepeater;

  localparam int NB = 96;
  localparam int NR = 10;
  localparam int NS = NB * NR;

  logic       clk_i = 1'b0;
  logic       rst;
  logic       clr;
  logic       di;
  logic       di_vld;
  logic       busy;
  logic       do_bit;
  logic [3:0] do_cnt;
  logic       do_vld;
  logic       do_last;
  logic       err;

  signal_derepeater #(.NBITS(NB), .NREP(NR)) dut (
    .clk_i  (clk_i),
    .rst    (rst),
    .clr    (clr),
    .di     (di),
    .di_vld (di_vld),
    .busy   (busy),
    .do_bit (do_bit),
    .do_cnt (do_cnt),
    .do_vld (do_vld),
    .do_last(do_last),
    .err    (err)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic       b;
    logic [3:0] c;
    logic       last;
  } exp_t;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   err_seen = 0;
  logic prev_vld = 1'b0;
  exp_t exp_q[$];
  int   first_q[$];
  logic fr [NS];

  always @(posedge clk_i) cyc++;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Reference: ones count per position summed across the repetitions of the frame.
  task automatic push_expect();
    for (int p = 0; p < NB; p++) begin
      int   ones;
      exp_t e;
      ones = 0;
      for (int r = 0; r < NR; r++) ones += int'(fr[r * NB + p]);
      e.b    = (2 * ones > NR);
      e.c    = 4'(ones);
      e.last = (p == NB - 1);
      exp_q.push_back(e);
    end
  endtask

  // Drive samples [0, n) of fr; a full frame also registers its expectations.
  task automatic send(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      while (gaps && $urandom_range(1, 0) == 1) step();
      di     = fr[i];
      di_vld = 1'b1;
      if (i == NS - 1) begin
        first_q.push_back(cyc + 3);
        push_expect();
      end
      step();
      di_vld = 1'b0;
      di     = 1'b0;
    end
  endtask

  task automatic wait_out_done();
    int t;
    t = 0;
    while (!busy && t < 20) begin step(); t++; end
    while (busy && t < 400) begin step(); t++; end
    check("out_done_in_time", int'(t < 400 && !busy), 1);
    step();
  endtask

  task automatic check_quiet(input string name);
    check(name, int'({busy, do_bit, do_cnt, do_vld, do_last, err}), 0);
  endtask

  always @(negedge clk_i) begin
    if (rst) begin
      prev_vld = 1'b0;
    end else begin
      if (err) err_seen++;
      if (do_vld) begin
        if (!prev_vld) begin
          if (first_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_burst: do_vld rose at cycle %0d, none required", cyc);
          end else begin
            check("first_vld_cycle", cyc, first_q.pop_front());
          end
        end
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_output: do_cnt=%0d with no expected bit", do_cnt);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("do", int'(do_bit), int'(e.b));
          check("do_cnt", int'(do_cnt), int'(e.c));
          check("do_last", int'(do_last), int'(e.last));
        end
      end else begin
        check("held_zero", int'({do_bit, do_cnt, do_last}), 0);
      end
      prev_vld = do_vld;
    end
  end

  initial begin
    int p;
    int base;
    rst    = 1'b1;
    clr    = 1'b0;
    di     = 1'b0;
    di_vld = 1'b0;
    repeat (3) step();
    check_quiet("reset_state");
    rst = 1'b0;
    step();

    // All ones, contiguous.
    for (int i = 0; i < NS; i++) fr[i] = 1'b1;
    send(NS, 1'b0);
    wait_out_done();

    // One position at 6/10, everything else zero.
    p = $urandom_range(NB - 1, 0);
    for (int i = 0; i < NS; i++) fr[i] = ((i % NB) == p) && (i / NB < 6);
    send(NS, 1'b0);
    wait_out_done();

    // 5/5 tie on every position.
    for (int i = 0; i < NS; i++) fr[i] = (((i / NB) + (i % NB)) % 2) == 0;
    send(NS, 1'b0);
    wait_out_done();

    // Random data contiguous, then identical data with gaps.
    for (int i = 0; i < NS; i++) fr[i] = 1'($urandom);
    send(NS, 1'b0);
    wait_out_done();
    send(NS, 1'b1);
    wait_out_done();

    // Samples offered during OUT are dropped with one err pulse each.
    for (int i = 0; i < NS; i++) fr[i] = 1'($urandom);
    send(NS, 1'b0);
    base = err_seen;
    for (int t = 0; t < 20 && !busy; t++) step();
    for (int k = 0; k < 5; k++) begin
      di     = 1'b1;
      di_vld = 1'b1;
      step();
    end
    di_vld = 1'b0;
    di     = 1'b0;
    wait_out_done();
    check("err_pulses", err_seen - base, 5);
    for (int i = 0; i < NS; i++) fr[i] = 1'($urandom);
    send(NS, 1'b1);
    wait_out_done();

    // clr abort after 500 samples, with a colliding sample that must be dropped.
    for (int i = 0; i < NS; i++) fr[i] = 1'b1;
    send(500, 1'b0);
    clr    = 1'b1;
    di     = 1'b1;
    di_vld = 1'b1;
    step();
    clr    = 1'b0;
    di_vld = 1'b0;
    di     = 1'b0;
    check_quiet("after_clr");
    for (int i = 0; i < NS; i++) fr[i] = 1'($urandom_range(3, 0) == 0);
    send(NS, 1'b0);
    wait_out_done();

    // rst abort after 500 samples.
    for (int i = 0; i < NS; i++) fr[i] = 1'b1;
    send(500, 1'b1);
    rst = 1'b1;
    step();
    check_quiet("after_rst");
    rst = 1'b0;
    for (int i = 0; i < NS; i++) fr[i] = 1'($urandom);
    send(NS, 1'b0);
    wait_out_done();

    repeat (4) step();
    check("exp_queue_drained", exp_q.size(), 0);
    check("latency_queue_drained", first_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
